// File: rtl/mem_arb_pkg.sv
// Shared types, SoC address map and decode helper for the memory request arbiter.
package mem_arb_pkg;

    // Defaults mirroring the ariane_soc configuration.
    localparam int NB_CORES    = 2;
    localparam int SOC_ID_W    = 4;
    localparam int NUM_REGIONS = 10;
    localparam int MAP_ADDR_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ERR  = 2'd2
    } arb_state_e;

    // Region order: Debug, ROM, CLINT, PLIC, UART, Timer, SPI, Ethernet, GPIO, DRAM.
    localparam logic [MAP_ADDR_W-1:0] REGION_BASE [NUM_REGIONS] = '{
        64'h0000_0000, 64'h0001_0000, 64'h0200_0000, 64'h0C00_0000, 64'h1000_0000,
        64'h1800_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000, 64'h8000_0000
    };
    localparam logic [MAP_ADDR_W-1:0] REGION_LEN [NUM_REGIONS] = '{
        64'h0000_1000, 64'h0001_0000, 64'h000C_0000, 64'h03FF_FFFF, 64'h0000_1000,
        64'h0000_1000, 64'h0080_0000, 64'h0001_0000, 64'h0000_1000, 64'h4000_0000
    };

    // One extra bit on every operand so base+length never wraps at the top of the map.
    function automatic logic addr_decode_ok(input logic [MAP_ADDR_W-1:0] addr);
        logic          ok;
        logic [MAP_ADDR_W:0] lim;
        ok = 1'b0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            lim = {1'b0, REGION_BASE[r]} + {1'b0, REGION_LEN[r]};
            if (({1'b0, addr} >= {1'b0, REGION_BASE[r]}) && ({1'b0, addr} < lim))
                ok = 1'b1;
        end
        return ok;
    endfunction

endpackage

// File: rtl/mem_req_rr_pick.sv
// Combinational round-robin picker: first eligible index at or after the pointer.
module mem_req_rr_pick #(
    parameter  int NrReq = 2,
    localparam int IdxW  = $clog2(NrReq)
) (
    input  logic [NrReq-1:0] i_elig,
    input  logic [IdxW-1:0]  i_ptr,
    output logic [IdxW-1:0]  o_idx,
    output logic             o_any
);

    // Scan from the farthest candidate back to the pointer so the nearest one wins.
    always_comb begin : p_pick
        int j;
        o_idx = '0;
        o_any = 1'b0;
        j     = 0;
        for (int k = NrReq - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            if (j >= NrReq) j = j - NrReq;
            if (i_elig[j]) begin
                o_idx = IdxW'(j);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one downstream request port between core requesters,
// with per-requester outstanding limits and local decode-error responses.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int NrReq          = NB_CORES,
    parameter  int AddrWidth      = 64,
    parameter  int IdWidth        = SOC_ID_W,
    parameter  int MaxOutstanding = 4,
    localparam int IdxW           = $clog2(NrReq),
    localparam int MstIdW         = IdWidth + IdxW,
    localparam int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [NrReq-1:0]                 req_valid_i,
    output logic [NrReq-1:0]                 req_ready_o,
    input  logic [NrReq-1:0][AddrWidth-1:0]  req_addr_i,
    input  logic [NrReq-1:0]                 req_we_i,
    input  logic [NrReq-1:0][IdWidth-1:0]    req_id_i,
    output logic                             mst_valid_o,
    input  logic                             mst_ready_i,
    output logic [AddrWidth-1:0]             mst_addr_o,
    output logic                             mst_we_o,
    output logic [MstIdW-1:0]                mst_id_o,
    input  logic                             rsp_valid_i,
    input  logic [MstIdW-1:0]                rsp_id_i,
    input  logic                             rsp_err_i,
    output logic [NrReq-1:0]                 rsp_valid_o,
    output logic [IdWidth-1:0]               rsp_id_o,
    output logic                             rsp_err_o
);

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic                 we;
        logic [MstIdW-1:0]    id;
    } mst_req_t;

    localparam logic [IdxW:0] NR_LIM = (IdxW + 1)'(NrReq);

    arb_state_e       r_state, w_state_nxt;
    mst_req_t         r_req;
    logic [IdxW-1:0]  r_ptr;
    logic [CntW-1:0]  r_cnt [NrReq];
    logic [NrReq-1:0] w_elig;
    logic [IdxW-1:0]  w_win;
    logic [IdxW-1:0]  w_rsp_idx;
    logic             w_any;
    logic             w_grant;
    logic             w_addr_ok;

    for (genvar g = 0; g < NrReq; g++) begin : g_elig
        assign w_elig[g] = req_valid_i[g] && (r_cnt[g] < CntW'(MaxOutstanding));
    end

    mem_req_rr_pick #(.NrReq(NrReq)) u_pick (
        .i_elig (w_elig),
        .i_ptr  (r_ptr),
        .o_idx  (w_win),
        .o_any  (w_any)
    );

    // Outputs are forced quiet while reset is held, even on the combinational paths.
    assign w_grant   = !rst_i && (r_state == IDLE) && w_any;
    assign w_addr_ok = addr_decode_ok(MAP_ADDR_W'(req_addr_i[w_win]));
    assign w_rsp_idx = rsp_id_i[MstIdW-1 -: IdxW];

    assign mst_valid_o = (r_state == FWD);
    assign mst_addr_o  = r_req.addr;
    assign mst_we_o    = r_req.we;
    assign mst_id_o    = r_req.id;

    // Accept strobe goes only to the current winner.
    always_comb begin
        req_ready_o = '0;
        if (w_grant) req_ready_o[w_win] = 1'b1;
    end

    // Response routing: downstream traffic has priority over a pending local decode error.
    always_comb begin
        rsp_valid_o = '0;
        rsp_id_o    = '0;
        rsp_err_o   = 1'b0;
        if (!rst_i) begin
            if (rsp_valid_i) begin
                if ({1'b0, w_rsp_idx} < NR_LIM) begin
                    rsp_valid_o[w_rsp_idx] = 1'b1;
                    rsp_id_o               = rsp_id_i[IdWidth-1:0];
                    rsp_err_o              = rsp_err_i;
                end
            end else if (r_state == ERR) begin
                rsp_valid_o[r_req.id[MstIdW-1 -: IdxW]] = 1'b1;
                rsp_id_o                                = r_req.id[IdWidth-1:0];
                rsp_err_o                               = 1'b1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant) w_state_nxt = w_addr_ok ? FWD : ERR;
            FWD:     if (mst_ready_i) w_state_nxt = IDLE;
            ERR:     if (!rsp_valid_i) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, latched request and round-robin pointer.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_req.addr <= req_addr_i[w_win];
                r_req.we   <= req_we_i[w_win];
                r_req.id   <= {w_win, req_id_i[w_win]};
                r_ptr      <= (w_win == IdxW'(NrReq - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end

    // Outstanding counters: grant increments, any delivered response decrements, 0 saturates.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NrReq; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NrReq; i++) begin
                if (req_ready_o[i] && !rsp_valid_o[i])
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                else if (!req_ready_o[i] && rsp_valid_o[i] && (r_cnt[i] != '0))
                    r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    a_mst_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (mst_valid_o && !mst_ready_i) |=>
            (mst_valid_o && $stable(mst_addr_o) && $stable(mst_we_o) && $stable(mst_id_o)));

    a_ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(req_ready_o));

    for (genvar g = 0; g < NrReq; g++) begin : g_chk
        a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
            (rsp_valid_o[g] && !req_ready_o[g]) |-> (r_cnt[g] != '0));
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with request/response scoreboards.
module tb_mem_req_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 64;
    localparam int IW  = 4;
    localparam int MIW = 5;

    logic                     clk_i = 1'b0;
    logic                     rst_i = 1'b1;
    logic [NR-1:0]            req_valid_i, req_ready_o, req_we_i, rsp_valid_o;
    logic [NR-1:0][AW-1:0]    req_addr_i;
    logic [NR-1:0][IW-1:0]    req_id_i;
    logic                     mst_valid_o, mst_ready_i, mst_we_o;
    logic                     rsp_valid_i, rsp_err_i, rsp_err_o;
    logic [AW-1:0]            mst_addr_o;
    logic [MIW-1:0]           mst_id_o, rsp_id_i;
    logic [IW-1:0]            rsp_id_o;

    mem_req_arbiter #(
        .NrReq(NR), .AddrWidth(AW), .IdWidth(IW), .MaxOutstanding(4)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
        .req_we_i(req_we_i), .req_id_i(req_id_i),
        .mst_valid_o(mst_valid_o), .mst_ready_i(mst_ready_i), .mst_addr_o(mst_addr_o),
        .mst_we_o(mst_we_o), .mst_id_o(mst_id_o),
        .rsp_valid_i(rsp_valid_i), .rsp_id_i(rsp_id_i), .rsp_err_i(rsp_err_i),
        .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_err_o(rsp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed { logic [AW-1:0] addr; logic we; logic [MIW-1:0] id; } mst_exp_t;
    typedef struct packed { logic [NR-1:0] vld; logic [IW-1:0] id; logic err; } rsp_exp_t;

    mst_exp_t    mst_q[$];
    rsp_exp_t    rsp_q[$];
    mst_exp_t    held;
    int          n_chk = 0, n_pass = 0, n_fail = 0;
    int unsigned cyc = 0, last_cyc = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rsp(input logic [NR-1:0] vld, input logic [IW-1:0] id,
                            input logic err, input bit front);
        rsp_exp_t e;
        e.vld = vld; e.id = id; e.err = err;
        if (front) rsp_q.push_front(e);
        else       rsp_q.push_back(e);
    endtask

    // Bounded wait for a downstream request, then compare against the oldest expectation.
    task automatic wait_mst(input string tag);
        mst_exp_t e;
        for (int i = 0; i < 8 && !mst_valid_o; i++) step();
        chk({tag, "_mvld"}, 64'(mst_valid_o), 64'd1);
        e = mst_q.pop_front();
        chk({tag, "_maddr"}, mst_addr_o, e.addr);
        chk({tag, "_mwe"}, 64'(mst_we_o), 64'(e.we));
        chk({tag, "_mid"}, 64'(mst_id_o), 64'(e.id));
    endtask

    // Bounded wait for a requester-side response, then compare against the oldest expectation.
    task automatic wait_rsp(input string tag, input int budget);
        rsp_exp_t e;
        for (int i = 0; i < budget && rsp_valid_o == '0; i++) step();
        e = rsp_q.pop_front();
        chk({tag, "_rvld"}, 64'(rsp_valid_o), 64'(e.vld));
        chk({tag, "_rid"}, 64'(rsp_id_o), 64'(e.id));
        chk({tag, "_rerr"}, 64'(rsp_err_o), 64'(e.err));
    endtask

    // Expect requester w to be granted now, forward it next cycle, accept it downstream.
    task automatic grant_fwd(input string tag, input int w, input bit keep);
        mst_exp_t e;
        chk({tag, "_rdy"}, 64'(req_ready_o), 64'd1 << w);
        e.addr = req_addr_i[w];
        e.we   = req_we_i[w];
        e.id   = {w[0], req_id_i[w]};
        mst_q.push_back(e);
        step();
        if (!keep) req_valid_i[w] = 1'b0;
        chk({tag, "_lat"}, 64'(mst_valid_o), 64'd1);
        wait_mst(tag);
        mst_ready_i = 1'b1;
        step();
        mst_ready_i = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        rst_i       = 1'b1;
        req_valid_i = '0;
        mst_ready_i = 1'b0;
        rsp_valid_i = 1'b0;
        rsp_id_i    = '0;
        rsp_err_i   = 1'b0;
        step();
        step();
        rst_i = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1);
    end

    initial begin
        req_addr_i = '0;
        req_we_i   = '0;
        req_id_i   = '0;
        do_reset();

        // Reset state
        chk("rst_mvld", 64'(mst_valid_o), 64'd0);
        chk("rst_maddr", mst_addr_o, 64'd0);
        chk("rst_mid", 64'(mst_id_o), 64'd0);
        chk("rst_rdy", 64'(req_ready_o), 64'd0);
        chk("rst_rvld", 64'(rsp_valid_o), 64'd0);

        // Single read to DRAM and its downstream response
        req_addr_i[0] = 64'h8000_0000; req_we_i[0] = 1'b0; req_id_i[0] = 4'h3;
        req_valid_i[0] = 1'b1;
        #1;
        grant_fwd("rd0", 0, 1'b0);
        rsp_valid_i = 1'b1; rsp_id_i = 5'b0_0011; rsp_err_i = 1'b0;
        push_rsp(2'b01, 4'h3, 1'b0, 1'b0);
        #1;
        wait_rsp("rd0_rsp", 0);
        step();
        rsp_valid_i = 1'b0;
        #1;

        // Contention: grants alternate, one every 2 cycles
        do_reset();
        req_addr_i[0] = 64'h8000_1000; req_we_i[0] = 1'b0; req_id_i[0] = 4'h1;
        req_addr_i[1] = 64'h1000_0008; req_we_i[1] = 1'b1; req_id_i[1] = 4'h2;
        req_valid_i = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) chk("cont_gap", 64'(cyc - last_cyc), 64'd2);
            last_cyc = cyc;
            grant_fwd("cont", k % 2, 1'b1);
        end
        req_valid_i = '0;

        // Outstanding limit
        do_reset();
        req_addr_i[0] = 64'h8000_0040; req_we_i[0] = 1'b0; req_id_i[0] = 4'h4;
        req_valid_i[0] = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) grant_fwd("lim", 0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("lim_blk", 64'(req_ready_o), 64'd0);
            step();
        end
        rsp_valid_i = 1'b1; rsp_id_i = {1'b0, 4'h4}; rsp_err_i = 1'b0;
        push_rsp(2'b01, 4'h4, 1'b0, 1'b0);
        #1;
        wait_rsp("lim_rsp", 0);
        chk("lim_blk_rsp", 64'(req_ready_o), 64'd0);
        step();
        rsp_valid_i = 1'b0;
        #1;
        grant_fwd("lim5", 0, 1'b0);

        // Decode error
        do_reset();
        req_addr_i[1] = 64'h5000_0000; req_we_i[1] = 1'b0; req_id_i[1] = 4'h5;
        req_valid_i[1] = 1'b1;
        #1;
        chk("derr_rdy", 64'(req_ready_o), 64'b10);
        push_rsp(2'b10, 4'h5, 1'b1, 1'b0);
        step();
        req_valid_i[1] = 1'b0;
        #1;
        chk("derr_nomst", 64'(mst_valid_o), 64'd0);
        wait_rsp("derr", 0);
        step();
        chk("derr_nomst2", 64'(mst_valid_o), 64'd0);
        chk("derr_done", 64'(rsp_valid_o), 64'd0);

        // Decode error colliding with a downstream response
        req_addr_i[0] = 64'h8000_0000; req_we_i[0] = 1'b0; req_id_i[0] = 4'h3;
        req_valid_i[0] = 1'b1;
        #1;
        grant_fwd("col_rd", 0, 1'b0);
        req_id_i[1] = 4'h6;
        req_valid_i[1] = 1'b1;
        #1;
        chk("col_rdy", 64'(req_ready_o), 64'b10);
        push_rsp(2'b10, 4'h6, 1'b1, 1'b0);
        step();
        req_valid_i[1] = 1'b0;
        rsp_valid_i = 1'b1; rsp_id_i = 5'b0_0011; rsp_err_i = 1'b0;
        // the downstream response overtakes the pending local error
        push_rsp(2'b01, 4'h3, 1'b0, 1'b1);
        #1;
        wait_rsp("col_dn", 0);
        step();
        rsp_valid_i = 1'b0;
        #1;
        wait_rsp("col_err", 0);
        step();
        chk("col_done", 64'(rsp_valid_o), 64'd0);

        // Backpressure: fields hold, no new accepts
        do_reset();
        req_addr_i[0] = 64'h4000_0100; req_we_i[0] = 1'b1; req_id_i[0] = 4'hA;
        req_addr_i[1] = 64'h8000_2000; req_we_i[1] = 1'b0; req_id_i[1] = 4'h2;
        req_valid_i = 2'b11;
        #1;
        chk("bp_rdy", 64'(req_ready_o), 64'b01);
        held.addr = req_addr_i[0]; held.we = req_we_i[0]; held.id = {1'b0, req_id_i[0]};
        mst_q.push_back(held);
        step();
        req_valid_i[0] = 1'b0;
        #1;
        held = mst_q.pop_front();
        for (int k = 0; k < 5; k++) begin
            chk("bp_vld", 64'(mst_valid_o), 64'd1);
            chk("bp_addr", mst_addr_o, held.addr);
            chk("bp_we", 64'(mst_we_o), 64'(held.we));
            chk("bp_id", 64'(mst_id_o), 64'(held.id));
            chk("bp_rdy0", 64'(req_ready_o), 64'd0);
            step();
        end
        mst_ready_i = 1'b1;
        #1;
        step();
        mst_ready_i = 1'b0;
        #1;
        chk("bp_next", 64'(req_ready_o), 64'b10);
        req_valid_i = '0;

        // Reset in the middle of FWD with requester 0 at its limit
        do_reset();
        req_addr_i[0] = 64'h8000_3000; req_we_i[0] = 1'b0; req_id_i[0] = 4'h7;
        req_valid_i[0] = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) grant_fwd("rst_pre", 0, 1'b1);
        chk("rst_rdy4", 64'(req_ready_o), 64'b01);
        step();
        req_valid_i[0] = 1'b0;
        #1;
        chk("rst_fwd", 64'(mst_valid_o), 64'd1);
        rst_i = 1'b1;
        #1;
        chk("rst_mid_mvld", 64'(mst_valid_o), 64'd0);
        chk("rst_mid_maddr", mst_addr_o, 64'd0);
        chk("rst_mid_mwe", 64'(mst_we_o), 64'd0);
        chk("rst_mid_mid", 64'(mst_id_o), 64'd0);
        chk("rst_mid_rdy", 64'(req_ready_o), 64'd0);
        chk("rst_mid_rvld", 64'(rsp_valid_o), 64'd0);
        step();
        rst_i = 1'b0;
        #1;
        req_addr_i[1] = 64'h1000_0000; req_we_i[1] = 1'b0; req_id_i[1] = 4'h1;
        req_valid_i = 2'b11;
        #1;
        grant_fwd("post_ptr", 0, 1'b1);
        req_valid_i[1] = 1'b0;
        #1;
        grant_fwd("post_cnt", 0, 1'b1);
        grant_fwd("post_cnt", 0, 1'b1);
        grant_fwd("post_cnt", 0, 1'b0);

        chk("sb_empty", 64'(mst_q.size() + rsp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Shares one downstream memory/peripheral request port between `NB_CORES` core requesters in the culsans SoC. Round-robin arbitration with per-requester outstanding-transaction limits, checks every address against the SoC address map, and answers unmapped addresses locally with a decode error. Downstream IDs are prefixed with the requester index so responses route back to the right core.

## Interface
- `NrReq`, default `ariane_soc::NB_CORES` (2): number of requesters, 2..4.
- `AddrWidth`, default 64: request address width.
- `IdWidth`, default `ariane_soc::IdWidth` (4): requester-side ID width.
- `MaxOutstanding`, default 4: per-requester outstanding limit, ≥1.
- Derived: `IdxW = $clog2(NrReq)`; downstream ID width `IdWidth+IdxW`.
- `clk_i`  in  1  clock. One clock; everything rising-edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `req_valid_i`  in  NrReq  per-requester request valid.
- `req_ready_o`  out  NrReq  per-requester accept. At most one bit high.
- `req_addr_i`  in  NrReq×AddrWidth  request address.
- `req_we_i`  in  NrReq  1 = write, 0 = read.
- `req_id_i`  in  NrReq×IdWidth  request ID.
- `mst_valid_o`  out  1  downstream request valid.
- `mst_ready_i`  in  1  downstream accept.
- `mst_addr_o`  out  AddrWidth  forwarded address.
- `mst_we_o`  out  1  forwarded write flag.
- `mst_id_o`  out  IdWidth+IdxW  `{requester index, req ID}`.
- `rsp_valid_i`  in  1  downstream response. No backpressure.
- `rsp_id_i`  in  IdWidth+IdxW  downstream response ID.
- `rsp_err_i`  in  1  downstream error flag.
- `rsp_valid_o`  out  NrReq  one-hot response strobe to a requester.
- `rsp_id_o`  out  IdWidth  response ID, low bits.
- `rsp_err_o`  out  1  response error flag.

## Operation
- FSM states: IDLE, FWD, ERR. Reset state: IDLE.
- Reset values: outputs 0, RR pointer 0, all counters 0.
- **Eligibility.** Requester i is eligible when `req_valid_i[i]` is high and `cnt[i] < MaxOutstanding`.
- **IDLE.** Pick the first eligible requester at or after the RR pointer, with wrap-around.
  - Assert `req_ready_o[winner]` combinationally.
  - Latch addr, we and `{winner, id}`.
  - Increment `cnt[winner]`.
  - Set the pointer to winner+1 mod NrReq.
  - Go to FWD if the address decodes, otherwise ERR.
  - If no requester is eligible, stay in IDLE and leave the pointer unchanged.
- **FWD.** Drive `mst_valid_o=1` with the latched fields. These fields are stable until `mst_ready_i`, then return to IDLE. `req_ready_o` is 0.
- **ERR.** Drive `rsp_valid_o[latched idx]=1`, `rsp_err_o=1`, `rsp_id_o=latched id`, then return to IDLE.
  - If `rsp_valid_i` is high in the same cycle, the downstream response wins and ERR holds.
- **Downstream response.** Route `rsp_valid_i` to `rsp_valid_o[rsp_id_i[top IdxW]]` in the same cycle, combinationally. `rsp_id_o` and `rsp_err_o` are passed through.
  - If the index is ≥ NrReq, drop the response silently and change no counter.
- **Counters.**
  - Decrement on every response delivered to that requester, local or downstream.
  - Increment and decrement in the same cycle leaves the count unchanged.
  - A decrement at 0 is a protocol violation. Covered by an assertion; the counter saturates at 0.
- **Address decode.** The address is valid if `base ≤ addr < base+length` for any of the 10 `ariane_soc` regions: Debug, ROM, CLINT, PLIC, UART, Timer, SPI, Ethernet, GPIO, DRAM.
  - Compute with AddrWidth+1-bit arithmetic so `base+length` cannot overflow.

## Timing
- Request accept to `mst_valid_o`: 1 cycle.
- Maximum throughput: 1 request per 2 cycles when `mst_ready_i` is held high.
- Decode-error response: 1 cycle after accept, delayed by any colliding downstream responses.
- Response path: 0 cycles, combinational.
- A stalled `mst_ready_i` holds FWD indefinitely. Requests are neither reordered nor dropped.
- An asynchronous reset mid-FWD or mid-ERR abandons the transaction. Counters clear, so the issuing requester must also be reset.

## Structure
- New package `mem_arb_pkg` holds:
  - `arb_state_e` (IDLE/FWD/ERR);
  - the region base/length arrays built from `ariane_soc` constants;
  - function `addr_decode_ok(addr)`.
- Sub-module `mem_req_rr_pick`: combinational round-robin picker. Inputs: eligible vector and pointer. Outputs: winner index and any-valid.
- Assertions:
  - `mst_*` stable while valid and not ready;
  - `req_ready_o` one-hot or zero;
  - no counter underflow.

## Test plan
- **Single read to DRAM.** Req0 sends read, addr 0x8000_0000, id 3.
  - Expect `mst_valid_o` the next cycle with `mst_id_o=0b0_0011`.
  - Response id 0b0_0011 → `rsp_valid_o=01`, `rsp_id_o=3`.
- **Contention.** Both requesters valid continuously, `mst_ready_i=1`.
  - Grants alternate 0,1,0,1, one every 2 cycles.
- **Outstanding limit.** MaxOutstanding=4, no responses returned.
  - Req0 gets 4 grants, then its `req_ready_o` stays 0.
  - One response for req0 → a fifth grant follows.
- **Decode error.** Req1 sends addr 0x5000_0000.
  - `mst_valid_o` never asserts.
  - The next cycle: `rsp_valid_o=10`, `rsp_err_o=1`.
  - Repeat with a downstream response in the same cycle: the error response is delayed by exactly 1 cycle.
- **Backpressure.** `mst_ready_i=0` for 5 cycles.
  - `mst_addr/we/id` stay constant and no new `req_ready_o` is issued.
- **Reset mid-FWD.** Assert `rst_i` during FWD.
  - All outputs go to 0 immediately.
  - After release the arbiter is in IDLE, the pointer is 0 and all counters are 0.
